// File: rtl/core_ls_lsu_ctrl_if.sv
// Data-memory bus between the LSU controller (master) and the memory (slave).
// Carries a valid/ready request channel and a valid-only response channel.
interface core_ls_lsu_ctrl_if #(
    parameter int XLEN    = 32,
    parameter int WMASK_W = 4
);
    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [XLEN-1:0]    mem_req_addr;
    logic               mem_req_wen;
    logic [WMASK_W-1:0] mem_req_wmask;
    logic [XLEN-1:0]    mem_req_wdata;
    logic               mem_rsp_valid;
    logic [XLEN-1:0]    mem_rsp_rdata;
    logic               mem_rsp_err;

    modport master (
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask, mem_req_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
    );

    modport slave (
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wmask, mem_req_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata, mem_rsp_err
    );
endinterface

// File: rtl/core_ls_lsu_ctrl.sv
// Load/store unit sequencing controller: accepts one operation at a time,
// lets the external alignment unit settle, runs one bus transaction guarded
// by a watchdog, then pulses the result (data, misalign or fault) for one cycle.
module core_ls_lsu_ctrl #(
    parameter int CORE_XLEN            = 32,
    parameter int CORE_LSU_INST_WIDTH  = 4,
    parameter int CORE_LSU_WMASK_WIDTH = 4,
    parameter int TIMEOUT_CYCLES       = 255,
    parameter int CNT_W                = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    // execute-stage request
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [CORE_LSU_INST_WIDTH-1:0]  req_inst,
    input  logic                            req_store,
    input  logic [CORE_XLEN-1:0]            req_addr,
    input  logic [CORE_XLEN-1:0]            req_wdata,
    // external combinational alignment unit
    output logic [CORE_LSU_INST_WIDTH-1:0]  al_inst,
    output logic [1:0]                      al_low_addr,
    output logic [CORE_XLEN-1:0]            al_wdata,
    output logic [CORE_XLEN-1:0]            al_rdata,
    input  logic [CORE_XLEN-1:0]            al_wdata_aligned,
    input  logic [CORE_LSU_WMASK_WIDTH-1:0] al_wmask,
    input  logic [CORE_XLEN-1:0]            al_rdata_aligned,
    input  logic                            al_unalign,
    // data-memory bus
    core_ls_lsu_ctrl_if.master              mem,
    // writeback side
    output logic                            rsp_valid,
    output logic [CORE_XLEN-1:0]            rsp_rdata,
    output logic                            rsp_misalign,
    output logic                            rsp_fault,
    output logic                            busy
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_CHK  = 3'd1;
    localparam logic [2:0] S_REQ  = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_RESP = 3'd4;

    localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]                      state;
    logic [CORE_LSU_INST_WIDTH-1:0]  inst_q;
    logic                            store_q;
    logic [CORE_XLEN-1:0]            addr_q;
    logic [CORE_XLEN-1:0]            wdata_q;
    logic [CORE_XLEN-1:0]            rdata_q;
    logic [CORE_LSU_WMASK_WIDTH-1:0] wmask_q;
    logic [CORE_XLEN-1:0]            bus_wdata_q;
    logic                            misalign_q;
    logic                            fault_q;
    logic [CNT_W-1:0]                wdog_q;

    // Sequencing FSM, exception flags and bus watchdog.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state      <= S_IDLE;
            misalign_q <= 1'b0;
            fault_q    <= 1'b0;
            wdog_q     <= '0;
        end else begin
            case (state)
                S_IDLE: if (req_valid) state <= S_CHK;
                S_CHK: begin
                    if (al_unalign) begin
                        misalign_q <= 1'b1;
                        state      <= S_RESP;
                    end else begin
                        state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem.mem_req_ready) begin
                        wdog_q <= '0;
                        state  <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    wdog_q <= wdog_q + 1'b1;
                    // A response in the last watchdog cycle beats the timeout.
                    if (mem.mem_rsp_valid) begin
                        fault_q <= mem.mem_rsp_err;
                        state   <= S_RESP;
                    end else if (wdog_q == WDOG_LAST) begin
                        fault_q <= 1'b1;
                        state   <= S_RESP;
                    end
                end
                S_RESP: begin
                    misalign_q <= 1'b0;
                    fault_q    <= 1'b0;
                    state      <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Operand capture on accept, bus-lane latch after alignment, read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q      <= '0;
            store_q     <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            wmask_q     <= '0;
            bus_wdata_q <= '0;
        end else begin
            if (state == S_IDLE && req_valid) begin
                inst_q  <= req_inst;
                store_q <= req_store;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
            end
            if (state == S_CHK && !al_unalign) begin
                wmask_q     <= store_q ? al_wmask : '0;
                bus_wdata_q <= al_wdata_aligned;
            end
            if (state == S_WAIT && mem.mem_rsp_valid && !mem.mem_rsp_err) begin
                rdata_q <= mem.mem_rsp_rdata;
            end
        end
    end

    assign req_ready   = (state == S_IDLE);
    assign busy        = (state != S_IDLE);

    assign al_inst     = inst_q;
    assign al_low_addr = addr_q[1:0];
    assign al_wdata    = wdata_q;
    assign al_rdata    = rdata_q;

    assign mem.mem_req_valid = (state == S_REQ);
    assign mem.mem_req_addr  = {addr_q[CORE_XLEN-1:2], 2'b00};
    assign mem.mem_req_wen   = store_q;
    assign mem.mem_req_wmask = wmask_q;
    assign mem.mem_req_wdata = bus_wdata_q;

    assign rsp_valid    = (state == S_RESP);
    assign rsp_rdata    = (state == S_RESP && !store_q && !misalign_q && !fault_q)
                          ? al_rdata_aligned : '0;
    assign rsp_misalign = misalign_q;
    assign rsp_fault    = fault_q;

endmodule

// File: tb/tb_core_ls_lsu_ctrl.sv
// Self-checking bench for core_ls_lsu_ctrl: a behavioural alignment unit and
// a scripted memory surround the DUT; expected results come from a byte-level
// reference model of the load/store semantics and the latency rules.
module tb_core_ls_lsu_ctrl;

    localparam int TB_TIMEOUT = 4;

    localparam logic [3:0] I_B  = 4'b0001;
    localparam logic [3:0] I_H  = 4'b0010;
    localparam logic [3:0] I_W  = 4'b0100;
    localparam logic [3:0] I_LU = 4'b1000;

    typedef struct {
        logic [3:0]  inst;
        logic        store;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] word;
        int          ready_dly;
        int          rsp_dly;
        bit          err;
        bit          no_rsp;
    } op_t;

    typedef struct {
        bit          found;
        int          lat;
        int          accept_wait;
        int          req_cyc;
        int          ready_busy;
        bit          bus_seen;
        bit          unstable;
        logic [31:0] addr;
        logic        wen;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        misalign;
        logic        fault;
        logic        post_valid;
        logic        post_busy;
        logic        post_flags;
    } obs_t;

    typedef struct {
        int          lat;
        bit          bus;
        logic [31:0] addr;
        logic        wen;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        misalign;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_store;
    logic [3:0]  req_inst;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  al_inst;
    logic [1:0]  al_low_addr;
    logic [31:0] al_wdata, al_rdata, al_wdata_aligned, al_rdata_aligned;
    logic [3:0]  al_wmask;
    logic        al_unalign;
    logic        rsp_valid, rsp_misalign, rsp_fault, busy;
    logic [31:0] rsp_rdata;
    logic [31:0] sh;

    int n_tests = 0;
    int n_fail  = 0;

    core_ls_lsu_ctrl_if #(.XLEN(32), .WMASK_W(4)) mem_bus ();

    core_ls_lsu_ctrl #(
        .CORE_XLEN(32), .CORE_LSU_INST_WIDTH(4), .CORE_LSU_WMASK_WIDTH(4),
        .TIMEOUT_CYCLES(TB_TIMEOUT), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_inst(req_inst),
        .req_store(req_store), .req_addr(req_addr), .req_wdata(req_wdata),
        .al_inst(al_inst), .al_low_addr(al_low_addr), .al_wdata(al_wdata),
        .al_rdata(al_rdata), .al_wdata_aligned(al_wdata_aligned), .al_wmask(al_wmask),
        .al_rdata_aligned(al_rdata_aligned), .al_unalign(al_unalign),
        .mem(mem_bus),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_misalign(rsp_misalign),
        .rsp_fault(rsp_fault), .busy(busy)
    );

    always #5 clk = ~clk;

    // Behavioural alignment unit: shifts store data into its lanes, extracts
    // and extends load data, flags misaligned halfword/word accesses.
    always_comb begin
        sh               = al_rdata >> {al_low_addr, 3'b000};
        al_unalign       = (al_inst[1] && al_low_addr[0]) || (al_inst[2] && al_low_addr != 2'b00);
        al_wdata_aligned = al_wdata << {al_low_addr, 3'b000};
        al_wmask         = 4'hF;
        al_rdata_aligned = sh;
        if (al_inst[0]) begin
            al_wmask         = 4'b0001 << al_low_addr;
            al_rdata_aligned = al_inst[3] ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
        end else if (al_inst[1]) begin
            al_wmask         = 4'b0011 << al_low_addr;
            al_rdata_aligned = al_inst[3] ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
        end
    end

    // Reference model: what a load/store must produce, byte by byte.
    function automatic exp_t model(op_t op);
        exp_t e;
        int size, off;
        logic [31:0] val;
        size = op.inst[0] ? 1 : (op.inst[1] ? 2 : 4);
        off  = int'(op.addr[1:0]);
        e.misalign = (off % size) != 0;
        e.bus      = !e.misalign;
        e.addr     = {op.addr[31:2], 2'b00};
        e.wen      = op.store;
        e.wmask    = 4'h0;
        e.wdata    = 32'h0;
        e.rdata    = 32'h0;
        e.fault    = 1'b0;
        if (e.misalign) begin
            e.lat = 3;
        end else begin
            e.fault = op.no_rsp || op.err;
            // idle + check + request cycles + wait cycles + response cycle
            e.lat = 2 + (op.ready_dly + 1) + (op.no_rsp ? TB_TIMEOUT : op.rsp_dly + 1) + 1;
            if (op.store) begin
                for (int b = 0; b < 4; b++) begin
                    if (b >= off && b < off + size) e.wmask[b] = 1'b1;
                    if (b >= off) e.wdata[8*b +: 8] = op.wdata[8*(b-off) +: 8];
                end
            end else if (!e.fault) begin
                val = 32'h0;
                for (int b = 0; b < size; b++) val[8*b +: 8] = op.word[8*(off+b) +: 8];
                if (!op.inst[3] && size < 4 && val[8*size-1])
                    for (int b = size; b < 4; b++) val[8*b +: 8] = 8'hFF;
                e.rdata = val;
            end
        end
        return e;
    endfunction

    function automatic op_t mk_op(logic [3:0] inst, logic store, logic [31:0] addr,
                                  logic [31:0] wdata, logic [31:0] word,
                                  int ready_dly, int rsp_dly, bit err, bit no_rsp);
        op_t op;
        op.inst = inst; op.store = store; op.addr = addr; op.wdata = wdata; op.word = word;
        op.ready_dly = ready_dly; op.rsp_dly = rsp_dly; op.err = err; op.no_rsp = no_rsp;
        return op;
    endfunction

    // Drives one operation and plays the memory; called and returns on a negedge.
    // Cycle 1 is the cycle in which the request is accepted.
    task automatic run_op(input op_t op, input bit keep_valid, output obs_t o);
        int k, wait_cyc;
        bit hs_next, in_wait;
        o.found = 0; o.lat = 0; o.accept_wait = 0; o.req_cyc = 0; o.ready_busy = 0;
        o.bus_seen = 0; o.unstable = 0; o.addr = 0; o.wen = 0; o.wmask = 0; o.wdata = 0;
        o.rdata = 0; o.misalign = 0; o.fault = 0; o.post_valid = 0; o.post_busy = 0;
        o.post_flags = 0;
        req_inst = op.inst; req_store = op.store; req_addr = op.addr; req_wdata = op.wdata;
        req_valid = 1'b1;
        while (!req_ready && o.accept_wait < 50) begin
            @(negedge clk);
            o.accept_wait++;
        end
        if (!req_ready) begin
            req_valid = 1'b0;
            return;
        end
        k = 1; wait_cyc = 0; hs_next = 0; in_wait = 0;
        while (k < 300 && !o.found) begin
            @(negedge clk);
            k++;
            if (!keep_valid) req_valid = 1'b0;
            if (req_ready) o.ready_busy++;
            if (hs_next) begin
                in_wait = 1;
                hs_next = 0;
            end
            mem_bus.mem_rsp_valid = 1'b0;
            mem_bus.mem_rsp_err   = 1'b0;
            mem_bus.mem_req_ready = 1'b0;
            mem_bus.mem_rsp_rdata = $urandom;
            if (rsp_valid) begin
                o.found    = 1;
                o.lat      = k;
                o.rdata    = rsp_rdata;
                o.misalign = rsp_misalign;
                o.fault    = rsp_fault;
            end else if (in_wait) begin
                if (!op.no_rsp && wait_cyc == op.rsp_dly) begin
                    mem_bus.mem_rsp_valid = 1'b1;
                    mem_bus.mem_rsp_err   = op.err;
                    mem_bus.mem_rsp_rdata = op.word;
                end
                wait_cyc++;
            end else begin
                if (mem_bus.mem_req_valid) begin
                    if (!o.bus_seen) begin
                        o.addr = mem_bus.mem_req_addr;   o.wen   = mem_bus.mem_req_wen;
                        o.wmask = mem_bus.mem_req_wmask; o.wdata = mem_bus.mem_req_wdata;
                    end else if (o.addr !== mem_bus.mem_req_addr || o.wen !== mem_bus.mem_req_wen ||
                                 o.wmask !== mem_bus.mem_req_wmask || o.wdata !== mem_bus.mem_req_wdata) begin
                        o.unstable = 1;
                    end
                    o.bus_seen = 1;
                    mem_bus.mem_req_ready = (o.req_cyc >= op.ready_dly);
                    hs_next = mem_bus.mem_req_ready;
                    o.req_cyc++;
                end
                // Stray responses before the handshake must be ignored.
                mem_bus.mem_rsp_valid = 1'($urandom_range(0, 1));
                mem_bus.mem_rsp_err   = 1'($urandom_range(0, 1));
            end
        end
        if (o.found && !keep_valid) begin
            @(negedge clk);
            o.post_valid = rsp_valid;
            o.post_busy  = busy;
            o.post_flags = rsp_misalign | rsp_fault;
        end
    endtask

    task automatic test_reset();
        n_tests++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (mem_bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req_valid: got %b want 0", mem_bus.mem_req_valid); end
        n_tests++; if (rsp_valid !== 1'b0 || rsp_misalign !== 1'b0 || rsp_fault !== 1'b0) begin
            n_fail++; $display("FAIL reset_rsp: got v=%b m=%b f=%b want 0 0 0", rsp_valid, rsp_misalign, rsp_fault); end
        n_tests++; if (al_inst !== 4'h0 || al_wdata !== 32'h0 || al_rdata !== 32'h0 || al_low_addr !== 2'b00) begin
            n_fail++; $display("FAIL reset_al: got inst=%h wdata=%h rdata=%h low=%b want zeros", al_inst, al_wdata, al_rdata, al_low_addr); end
        n_tests++; if (mem_bus.mem_req_addr !== 32'h0 || mem_bus.mem_req_wmask !== 4'h0 || mem_bus.mem_req_wen !== 1'b0 || rsp_rdata !== 32'h0) begin
            n_fail++; $display("FAIL reset_bus: got addr=%h wmask=%h wen=%b rdata=%h want zeros", mem_bus.mem_req_addr, mem_bus.mem_req_wmask, mem_bus.mem_req_wen, rsp_rdata); end
    endtask

    task automatic test_word_load();
        obs_t o;
        run_op(mk_op(I_W, 1'b0, 32'h1000_0004, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0), 0, o);
        n_tests++; if (o.lat !== 5) begin n_fail++; $display("FAIL word_load_latency: got %0d want 5", o.lat); end
        n_tests++; if (o.addr !== 32'h1000_0004 || o.wen !== 1'b0 || o.wmask !== 4'h0) begin
            n_fail++; $display("FAIL word_load_bus: got addr=%h wen=%b wmask=%h want 10000004 0 0", o.addr, o.wen, o.wmask); end
        n_tests++; if (o.rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL word_load_rdata: got %h want deadbeef", o.rdata); end
        n_tests++; if (o.post_valid !== 1'b0 || o.post_busy !== 1'b0) begin
            n_fail++; $display("FAIL word_load_pulse: got valid=%b busy=%b after response, want 0 0", o.post_valid, o.post_busy); end
    endtask

    task automatic test_byte_load();
        obs_t o;
        run_op(mk_op(I_B, 1'b0, 32'h2000_0003, 32'h0, 32'h80FF_0000, 0, 0, 0, 0), 0, o);
        n_tests++; if (o.rdata !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL byte_load_signed: got %h want ffffff80", o.rdata); end
        run_op(mk_op(I_B | I_LU, 1'b0, 32'h2000_0003, 32'h0, 32'h80FF_0000, 0, 0, 0, 0), 0, o);
        n_tests++; if (o.rdata !== 32'h0000_0080) begin n_fail++; $display("FAIL byte_load_unsigned: got %h want 00000080", o.rdata); end
    endtask

    task automatic test_half_store();
        obs_t o;
        run_op(mk_op(I_H, 1'b1, 32'h3000_0002, 32'h0000_1234, 32'hFFFF_FFFF, 0, 0, 0, 0), 0, o);
        n_tests++; if (o.wmask !== 4'b1100 || o.wdata !== 32'h1234_0000 || o.wen !== 1'b1) begin
            n_fail++; $display("FAIL half_store_bus: got wmask=%b wdata=%h wen=%b want 1100 12340000 1", o.wmask, o.wdata, o.wen); end
        n_tests++; if (o.rdata !== 32'h0 || o.lat !== 5) begin
            n_fail++; $display("FAIL half_store_rsp: got rdata=%h lat=%0d want 0 5", o.rdata, o.lat); end
    endtask

    task automatic test_misaligned();
        obs_t o;
        run_op(mk_op(I_W, 1'b0, 32'h4000_0001, 32'h0, 32'h1234_5678, 0, 0, 0, 0), 0, o);
        n_tests++; if (o.bus_seen !== 1'b0) begin n_fail++; $display("FAIL misalign_no_bus: got bus request=%b want 0", o.bus_seen); end
        n_tests++; if (o.misalign !== 1'b1 || o.fault !== 1'b0 || o.rdata !== 32'h0) begin
            n_fail++; $display("FAIL misalign_rsp: got m=%b f=%b rdata=%h want 1 0 0", o.misalign, o.fault, o.rdata); end
        n_tests++; if (o.lat !== 3) begin n_fail++; $display("FAIL misalign_latency: got %0d want 3", o.lat); end
        n_tests++; if (o.post_flags !== 1'b0) begin n_fail++; $display("FAIL misalign_clear: got flags=%b after response want 0", o.post_flags); end
    endtask

    task automatic test_bus_faults();
        obs_t o;
        run_op(mk_op(I_W, 1'b1, 32'h5000_0010, 32'hCAFE_F00D, 32'h0, 10, 0, 0, 0), 0, o);
        n_tests++; if (o.req_cyc !== 11 || o.unstable !== 1'b0) begin
            n_fail++; $display("FAIL backpressure: got req cycles=%0d unstable=%b want 11 0", o.req_cyc, o.unstable); end
        n_tests++; if (o.wdata !== 32'hCAFE_F00D || o.wmask !== 4'hF || o.lat !== 15) begin
            n_fail++; $display("FAIL backpressure_rsp: got wdata=%h wmask=%h lat=%0d want cafef00d f 15", o.wdata, o.wmask, o.lat); end
        run_op(mk_op(I_W, 1'b0, 32'h5000_0020, 32'h0, 32'h1111_2222, 0, 2, 1, 0), 0, o);
        n_tests++; if (o.fault !== 1'b1 || o.rdata !== 32'h0 || o.lat !== 7) begin
            n_fail++; $display("FAIL bus_error: got f=%b rdata=%h lat=%0d want 1 0 7", o.fault, o.rdata, o.lat); end
        n_tests++; if (o.post_flags !== 1'b0) begin n_fail++; $display("FAIL fault_clear: got flags=%b want 0", o.post_flags); end
        run_op(mk_op(I_W, 1'b0, 32'h5000_0030, 32'h0, 32'h0, 0, 0, 0, 1), 0, o);
        n_tests++; if (o.fault !== 1'b1 || o.lat !== 2 + 1 + TB_TIMEOUT + 1) begin
            n_fail++; $display("FAIL timeout: got f=%b lat=%0d want 1 %0d", o.fault, o.lat, 2 + 1 + TB_TIMEOUT + 1); end
        // Response in the final watchdog cycle must win over the timeout.
        run_op(mk_op(I_W, 1'b0, 32'h5000_0040, 32'h0, 32'h7777_8888, 0, TB_TIMEOUT - 1, 0, 0), 0, o);
        n_tests++; if (o.fault !== 1'b0 || o.rdata !== 32'h7777_8888) begin
            n_fail++; $display("FAIL timeout_edge: got f=%b rdata=%h want 0 77778888", o.fault, o.rdata); end
    endtask

    task automatic test_reset_abort();
        int n, seen;
        req_inst = I_W; req_store = 1'b0; req_addr = 32'h6000_0000; req_wdata = 32'h0; req_valid = 1'b1;
        @(negedge clk); req_valid = 1'b0;
        n = 0;
        while (!mem_bus.mem_req_valid && n < 10) begin @(negedge clk); n++; end
        n_tests++; if (mem_bus.mem_req_valid !== 1'b1) begin n_fail++; $display("FAIL abort_reach_req: got mem_req_valid=%b want 1", mem_bus.mem_req_valid); end
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        n_tests++; if (mem_bus.mem_req_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_req: got mem_req_valid=%b req_ready=%b want 0 1", mem_bus.mem_req_valid, req_ready); end
        req_valid = 1'b1; req_addr = 32'h6000_0004;
        @(negedge clk); req_valid = 1'b0;
        n = 0;
        while (!mem_bus.mem_req_valid && n < 10) begin @(negedge clk); n++; end
        mem_bus.mem_req_ready = 1'b1;
        @(negedge clk); mem_bus.mem_req_ready = 1'b0;
        rst = 1'b1; mem_bus.mem_rsp_valid = 1'b1; mem_bus.mem_rsp_err = 1'b0; mem_bus.mem_rsp_rdata = 32'hABCD_0123;
        @(negedge clk); rst = 1'b0; mem_bus.mem_rsp_valid = 1'b0;
        n_tests++; if (req_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || mem_bus.mem_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL abort_wait: got ready=%b busy=%b rsp_valid=%b mem_req_valid=%b want 1 0 0 0", req_ready, busy, rsp_valid, mem_bus.mem_req_valid); end
        seen = 0;
        repeat (4) begin @(negedge clk); if (rsp_valid) seen++; end
        n_tests++; if (seen !== 0) begin n_fail++; $display("FAIL abort_no_rsp: got %0d rsp_valid cycles want 0", seen); end
    endtask

    task automatic test_back_to_back();
        obs_t oa, ob;
        op_t  a, b;
        exp_t eb;
        a = mk_op(I_W, 1'b0, 32'h7000_0008, 32'h0, 32'h0BAD_CAFE, 1, 1, 0, 0);
        b = mk_op(I_B, 1'b1, 32'h7000_0001, 32'h0000_00A5, 32'h0, 0, 0, 0, 0);
        eb = model(b);
        run_op(a, 1, oa);
        n_tests++; if (oa.ready_busy !== 0 || oa.rdata !== 32'h0BAD_CAFE) begin
            n_fail++; $display("FAIL b2b_first: got ready-while-busy=%0d rdata=%h want 0 0badcafe", oa.ready_busy, oa.rdata); end
        run_op(b, 0, ob);
        n_tests++; if (ob.accept_wait !== 1) begin n_fail++; $display("FAIL b2b_accept: got wait=%0d want 1", ob.accept_wait); end
        n_tests++; if (ob.wmask !== eb.wmask || ob.wdata !== eb.wdata || ob.lat !== eb.lat) begin
            n_fail++; $display("FAIL b2b_second: got wmask=%h wdata=%h lat=%0d want %h %h %0d", ob.wmask, ob.wdata, ob.lat, eb.wmask, eb.wdata, eb.lat); end
    endtask

    task automatic test_random();
        op_t  op;
        obs_t o;
        exp_t e;
        int   sz;
        for (int i = 0; i < 40; i++) begin
            sz = $urandom_range(0, 2);
            op.inst  = 4'(1 << sz);
            op.store = 1'($urandom_range(0, 1));
            if (!op.store && sz < 2 && $urandom_range(0, 1) == 1) op.inst[3] = 1'b1;
            op.addr  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 1) op.addr[0] = 1'b0;
                if (sz == 2) op.addr[1:0] = 2'b00;
            end
            op.wdata     = $urandom;
            op.word      = $urandom;
            op.ready_dly = $urandom_range(0, 3);
            op.rsp_dly   = $urandom_range(0, TB_TIMEOUT - 1);
            op.err       = ($urandom_range(0, 9) == 0);
            op.no_rsp    = ($urandom_range(0, 19) == 0);
            e = model(op);
            run_op(op, 0, o);
            n_tests++; if (!o.found || o.lat !== e.lat) begin
                n_fail++; $display("FAIL rand%0d_latency: got found=%b lat=%0d want %0d", i, o.found, o.lat, e.lat); end
            n_tests++; if (o.rdata !== e.rdata || o.misalign !== e.misalign || o.fault !== e.fault) begin
                n_fail++; $display("FAIL rand%0d_rsp: got rdata=%h m=%b f=%b want %h %b %b", i, o.rdata, o.misalign, o.fault, e.rdata, e.misalign, e.fault); end
            n_tests++; if (o.bus_seen !== e.bus || o.unstable !== 1'b0 || o.ready_busy !== 0 || o.post_valid !== 1'b0) begin
                n_fail++; $display("FAIL rand%0d_proto: got bus=%b unstable=%b ready_busy=%0d post_valid=%b want %b 0 0 0", i, o.bus_seen, o.unstable, o.ready_busy, o.post_valid, e.bus); end
            if (e.bus) begin
                n_tests++; if (o.addr !== e.addr || o.wen !== e.wen || o.wmask !== e.wmask || (op.store && o.wdata !== e.wdata)) begin
                    n_fail++; $display("FAIL rand%0d_bus: got addr=%h wen=%b wmask=%h wdata=%h want %h %b %h %h", i, o.addr, o.wen, o.wmask, o.wdata, e.addr, e.wen, e.wmask, e.wdata); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_inst = '0; req_store = 1'b0; req_addr = '0; req_wdata = '0;
        mem_bus.mem_req_ready = 1'b0; mem_bus.mem_rsp_valid = 1'b0;
        mem_bus.mem_rsp_rdata = '0;   mem_bus.mem_rsp_err = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        test_reset();
        test_word_load();
        test_byte_load();
        test_half_store();
        test_misaligned();
        test_bus_faults();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_time_limit: simulation still running at %0t", $time);
        $fatal(1, "time limit");
    end

endmodule

// File: doc/core_ls_lsu_ctrl.md
Name: core_ls_lsu_ctrl

Overview:
Sequencing controller for the load/store unit datapath. It accepts one memory operation at a time from the execute stage and drives the LSU alignment unit, which is external and combinational. It then performs a valid/ready transaction on the data-memory bus and returns the aligned load data, or an exception, to the writeback side. A watchdog counter turns a non-responding bus into an access fault.

Parameters:
- TIMEOUT_CYCLES, 255: maximum cycles spent in WAIT before a bus timeout fault is forced; legal range 1..65535.
- CNT_W, 16: width of the watchdog counter.

Ports:
- clk  in  1  single core clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  execute stage presents an LSU operation
- req_ready  out  1  controller can accept; high only in IDLE
- req_inst  in  CORE_LSU_INST_WIDTH  LSU instruction bus (B/H/W/LU bits)
- req_store  in  1  1 = store, 0 = load
- req_addr  in  CORE_XLEN  byte address
- req_wdata  in  CORE_XLEN  unaligned store data
- al_inst  out  CORE_LSU_INST_WIDTH  registered inst to the alignment unit
- al_low_addr  out  2  registered addr[1:0] to the alignment unit
- al_wdata  out  CORE_XLEN  registered store data to the alignment unit
- al_rdata  out  CORE_XLEN  registered bus read data to the alignment unit
- al_wdata_aligned  in  CORE_XLEN  lane-shifted store data
- al_wmask  in  CORE_LSU_WMASK_WIDTH  byte enables
- al_rdata_aligned  in  CORE_XLEN  extended load result
- al_unalign  in  1  misaligned access flag
- mem_req_valid  out  1  bus request
- mem_req_ready  in  1  bus accepts request
- mem_req_addr  out  CORE_XLEN  {addr[31:2],2'b00}
- mem_req_wen  out  1  write enable
- mem_req_wmask  out  CORE_LSU_WMASK_WIDTH  byte enables; 0 on loads
- mem_req_wdata  out  CORE_XLEN  aligned store data
- mem_rsp_valid  in  1  bus response
- mem_rsp_rdata  in  CORE_XLEN  raw read word
- mem_rsp_err  in  1  bus error
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  CORE_XLEN  load result; 0 for stores and faults
- rsp_misalign  out  1  misaligned exception
- rsp_fault  out  1  access fault (bus error or timeout)
- busy  out  1  state != IDLE

Behaviour:
- All outputs are registered or decoded from registered state.
- Reset (takes priority over any activity): state = IDLE; all outputs 0 except req_ready = 1; all capture registers and the watchdog counter are 0.
- States: IDLE, CHK, REQ, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid: capture inst, store, addr, wdata into registers; go to CHK.
  - The al_* outputs follow the captured registers.
- CHK (one cycle; the alignment unit settles):
  - al_unalign = 1: set rsp_misalign, go to RESP; no bus traffic is generated.
  - Otherwise: latch al_wmask and al_wdata_aligned into the bus registers, go to REQ.
- REQ:
  - mem_req_valid = 1, with address, wen, wmask and wdata held stable until mem_req_ready.
  - On mem_req_valid & mem_req_ready: go to WAIT; clear the watchdog.
- WAIT:
  - Watchdog increments every cycle.
  - mem_rsp_valid & mem_rsp_err: rsp_fault = 1, go to RESP.
  - mem_rsp_valid & !mem_rsp_err: capture mem_rsp_rdata into al_rdata, go to RESP.
  - Watchdog == TIMEOUT_CYCLES-1 with no response: rsp_fault = 1, go to RESP. A response arriving in that same cycle wins over the timeout.
- RESP (one cycle):
  - rsp_valid = 1.
  - rsp_rdata = al_rdata_aligned for a non-faulting load; otherwise 0.
  - Go to IDLE. rsp_misalign and rsp_fault are cleared on exit.
- Latency:
  - Misaligned access: 3 cycles from the accept edge to the rsp_valid pulse.
  - Normal access with mem_req_ready = 1 and a 1-cycle response: 5 cycles.
- Bus rules:
  - A response seen in REQ (before the handshake) is ignored.
  - A response seen in IDLE or CHK is ignored.
- Reset during REQ or WAIT aborts the transaction: mem_req_valid drops the next cycle and no rsp_valid is issued.
- req_valid while busy is ignored (req_ready = 0). The requester holds the request until accepted.

Test Plan:
1. Word load: addr 0x1000_0004, memory returns 0xDEAD_BEEF.
   -> mem_req_addr = 0x1000_0004, wen = 0, wmask = 0; rsp_valid with rsp_rdata = 0xDEAD_BEEF; 5-cycle latency.
2. Signed byte load: addr 0x...03, word 0x80FF_0000.
   -> rsp_rdata = 0xFFFF_FF80.
   Same access with the LU bit set: rsp_rdata = 0x0000_0080.
3. Halfword store: data 0x0000_1234 at addr 0x...02.
   -> mem_req_wmask = 4'b1100, mem_req_wdata = 0x1234_0000, wen = 1; rsp_rdata = 0.
4. Misaligned word load at addr 0x...01.
   -> no mem_req_valid ever asserted; rsp_valid with rsp_misalign = 1 three cycles after accept.
5. Bus backpressure and errors:
   - mem_req_ready held low for 10 cycles -> request fields stay stable for all 10 cycles.
   - mem_rsp_err = 1 -> rsp_fault = 1, rsp_rdata = 0.
   - No response with TIMEOUT_CYCLES = 4 -> rsp_fault asserted after 4 WAIT cycles.
6. Reset and busy behaviour:
   - rst asserted during WAIT -> next cycle state IDLE, req_ready = 1, no rsp_valid.
   - Back-to-back req_valid -> second request accepted only after RESP.
